// File: rtl/uart_rxq_if.sv
// Receive stream handshake between uart_rxq and its consumer.
// The master drives the FIFO head; the slave answers with tready.
interface uart_rxq_if #(
  parameter int unsigned DW = 8
);
  logic          str_tvalid;
  logic [DW-1:0] str_tdata;
  logic [1:0]    str_tuser;
  logic          str_tready;

  modport master (output str_tvalid, output str_tdata, output str_tuser, input str_tready);
  modport slave  (input str_tvalid, input str_tdata, input str_tuser, output str_tready);
endinterface

// File: rtl/uart_rxq.sv
// UART receiver with runtime bit-period divider, break detection and a
// show-ahead character FIFO carrying per-character frame/parity status.
module uart_rxq #(
  parameter int unsigned DW = 8,
  parameter string       PT = "NONE",
  parameter int unsigned SW = 1,
  parameter int unsigned BW = 16,
  parameter int unsigned FD = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [BW-1:0] cfg_div,
  output logic          error_fifo,
  input  logic          err_clr,
  output logic          line_break,
  input  logic          uart_rxd,
  uart_rxq_if.master    str
);
  localparam int unsigned AW        = $clog2(FD);
  localparam logic        PAR_EN    = (PT != "NONE");
  localparam logic        PAR_ODD   = (PT == "ODD");
  localparam logic [3:0]  LAST_DATA = 4'(DW - 1);
  localparam logic [3:0]  LAST_STOP = 4'(SW - 1);
  localparam logic [AW:0] FULL_CNT  = FD[AW:0];

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;

  function automatic logic par_exp(input logic [DW-1:0] d);
    return PAR_ODD ? ~(^d) : ^d;
  endfunction

  state_e          state_q, state_d;
  logic            sync1_q, rxs_q, rxs_d1_q;
  logic [BW-1:0]   cnt_q, cnt_d, div_q, div_d;
  logic [3:0]      bit_q, bit_d;
  logic [DW-1:0]   data_q, data_d;
  logic            pe_q, pe_d, fe_q, fe_d, zero_q, zero_d;
  logic            line_break_q, err_q;
  logic [DW+1:0]   mem_q [0:FD-1];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     fcnt_q;
  logic            tick_s, fall_s, wr_s, brk_s, valid_s, pop_s, full_s, push_s, ovf_s;
  logic [BW-1:0]   half_s;
  logic [DW+1:0]   wdat_s, head_s;

  // (cfg_div-1)>>1 equals H-1, so the counter reaches 0 exactly H cycles after loading
  assign half_s = (cfg_div - {{(BW-1){1'b0}}, 1'b1}) >> 1;
  assign fall_s = rxs_d1_q & ~rxs_q;
  assign tick_s = (cnt_q == {BW{1'b0}});

  // Frame FSM: next state, bit sampling and frame-end decision
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pe_d    = pe_q;
    fe_d    = fe_q;
    zero_d  = zero_q;
    wr_s    = 1'b0;
    brk_s   = 1'b0;
    wdat_s  = {fe_q, pe_q, data_q};
    case (state_q)
      S_IDLE: begin
        if (fall_s) begin
          state_d = S_START;
          div_d   = cfg_div;
          cnt_d   = half_s;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (!tick_s) begin
          cnt_d = cnt_q - {{(BW-1){1'b0}}, 1'b1};
        end else if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DATA;
          cnt_d   = div_q;
          bit_d   = 4'd0;
          pe_d    = 1'b0;
          fe_d    = 1'b0;
          zero_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (!tick_s) begin
          cnt_d = cnt_q - {{(BW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d  = div_q;
          data_d = {rxs_q, data_q[DW-1:1]};
          zero_d = zero_q & ~rxs_q;
          if (bit_q == LAST_DATA) begin
            bit_d   = 4'd0;
            state_d = PAR_EN ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (!tick_s) begin
          cnt_d = cnt_q - {{(BW-1){1'b0}}, 1'b1};
        end else begin
          cnt_d   = div_q;
          pe_d    = (rxs_q != par_exp(data_q));
          zero_d  = zero_q & ~rxs_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (!tick_s) begin
          cnt_d = cnt_q - {{(BW-1){1'b0}}, 1'b1};
        end else if (bit_q == LAST_STOP) begin
          cnt_d = div_q;
          bit_d = 4'd0;
          if (zero_q && !rxs_q) begin
            brk_s   = 1'b1;
            state_d = S_BREAK;
          end else begin
            wr_s    = 1'b1;
            wdat_s  = {fe_q | ~rxs_q, pe_q, data_q};
            state_d = S_IDLE;
          end
        end else begin
          cnt_d  = div_q;
          fe_d   = fe_q | ~rxs_q;
          zero_d = zero_q & ~rxs_q;
          bit_d  = bit_q + 4'd1;
        end
      end
      S_BREAK: begin
        if (rxs_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_BREAK;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Synchronizer and frame FSM state registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q  <= 1'b1;
      rxs_q    <= 1'b1;
      rxs_d1_q <= 1'b1;
      state_q  <= S_IDLE;
      cnt_q    <= {BW{1'b0}};
      div_q    <= {BW{1'b0}};
      bit_q    <= 4'd0;
      data_q   <= {DW{1'b0}};
      pe_q     <= 1'b0;
      fe_q     <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      sync1_q  <= uart_rxd;
      rxs_q    <= sync1_q;
      rxs_d1_q <= rxs_q;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      pe_q     <= pe_d;
      fe_q     <= fe_d;
      zero_q   <= zero_d;
    end
  end

  // FIFO handshake; a full FIFO still accepts a write when the head leaves in the same cycle
  always_comb begin
    valid_s = (fcnt_q != {(AW+1){1'b0}});
    pop_s   = valid_s & str.str_tready;
    full_s  = (fcnt_q == FULL_CNT);
    push_s  = wr_s & (~full_s | pop_s);
    ovf_s   = wr_s & full_s & ~pop_s;
    head_s  = mem_q[rd_q];
  end

  // FIFO storage; contents need no reset because the outputs are masked when empty
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_q] <= wdat_s;
    end
  end

  // FIFO pointers, occupancy, sticky overflow and break pulse
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q         <= {AW{1'b0}};
      rd_q         <= {AW{1'b0}};
      fcnt_q       <= {(AW+1){1'b0}};
      err_q        <= 1'b0;
      line_break_q <= 1'b0;
    end else begin
      wr_q <= push_s ? wr_q + AW'(1) : wr_q;
      rd_q <= pop_s ? rd_q + AW'(1) : rd_q;
      case ({push_s, pop_s})
        2'b10:   fcnt_q <= fcnt_q + {{AW{1'b0}}, 1'b1};
        2'b01:   fcnt_q <= fcnt_q - {{AW{1'b0}}, 1'b1};
        default: fcnt_q <= fcnt_q;
      endcase
      if (ovf_s) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end else begin
        err_q <= err_q;
      end
      line_break_q <= brk_s;
    end
  end

  assign str.str_tvalid = valid_s;
  assign str.str_tdata  = valid_s ? head_s[DW-1:0] : {DW{1'b0}};
  assign str.str_tuser  = valid_s ? head_s[DW+1:DW] : 2'b00;
  assign error_fifo     = err_q;
  assign line_break     = line_break_q;
endmodule

// File: tb/tb_uart_rxq.sv
// Directed/randomized bench for uart_rxq (DW=8, EVEN parity, SW=1, FD=4)
// against a queue-based character model.
module tb_uart_rxq;
  localparam int DW = 8;
  localparam int BW = 16;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [BW-1:0] cfg_div;
  logic          err_clr;
  logic          uart_rxd;
  logic          error_fifo;
  logic          line_break;

  uart_rxq_if #(.DW(DW)) str ();

  uart_rxq #(.DW(DW), .PT("EVEN"), .SW(1), .BW(BW), .FD(FD)) dut (
    .clk(clk), .rst(rst), .cfg_div(cfg_div), .error_fifo(error_fifo),
    .err_clr(err_clr), .line_break(line_break), .uart_rxd(uart_rxd), .str(str)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [9:0] mq[$];
  bit         merr = 1'b0;
  int         idx = 0;
  int         pulses = 0;
  logic       vtrace [0:1023];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outcome of one received frame: break, or a stored/dropped character
  task automatic model_frame(input logic [7:0] d, input logic p, input logic s, output bit brk);
    brk = (d == 8'h00) && !p && !s;
    if (!brk) begin
      if (mq.size() < FD) mq.push_back({~s, (p != ^d), d});
      else merr = 1'b1;
    end
  endtask

  task automatic send_bits(input logic [15:0] bits, input int nb, input int per);
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < per; k++) begin
        @(negedge clk);
        if (idx < 1024) vtrace[idx] = str.str_tvalid;
        idx++;
        if (line_break === 1'b1) pulses++;
        uart_rxd = bits[b];
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (line_break === 1'b1) pulses++;
      uart_rxd = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int per);
    bit brk;
    idx = 0;
    pulses = 0;
    send_bits({5'b00000, s, p, d, 1'b0}, 11, per);
    model_frame(d, p, s, brk);
    check("break_pulses", pulses, brk ? 32'd1 : 32'd0);
    check("error_fifo", error_fifo, {31'd0, merr});
    if (!s) idle(5);
  endtask

  task automatic drain();
    logic [9:0] w;
    while (mq.size() > 0) begin
      @(negedge clk);
      w = mq.pop_front();
      check("head_valid", str.str_tvalid, 32'd1);
      check("head_data", str.str_tdata, {24'd0, w[7:0]});
      check("head_user", str.str_tuser, {30'd0, w[9:8]});
      str.str_tready = 1'b1;
      @(negedge clk);
      str.str_tready = 1'b0;
    end
    @(negedge clk);
    check("fifo_empty", str.str_tvalid, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  d;
    logic [7:0]  d2;
    logic        p;
    logic        s;
    logic [10:0] fb;
    bit          brk;

    uart_rxd = 1'b1;
    cfg_div = 16'd9;
    err_clr = 1'b0;
    str.str_tready = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tvalid", str.str_tvalid, 32'd0);
    check("rst_tdata", str.str_tdata, 32'd0);
    check("rst_tuser", str.str_tuser, 32'd0);
    check("rst_error_fifo", error_fifo, 32'd0);
    check("rst_line_break", line_break, 32'd0);
    rst = 1'b1;
    idle(5);

    // Good frame with exact write latency
    send_frame(8'hA5, 1'b0, 1'b1, 10);
    check("valid_at_107", vtrace[107], 32'd0);
    check("valid_at_108", vtrace[108], 32'd1);
    drain();

    // Random good frames
    for (int i = 0; i < 3; i++) begin
      d = 8'($urandom);
      send_frame(d, ^d, 1'b1, 10);
      idle(3);
    end
    drain();

    // Parity and framing errors
    send_frame(8'hA5, 1'b1, 1'b1, 10);
    send_frame(8'h3C, 1'b0, 1'b0, 10);
    drain();

    // Random mix of errors and occasional break frames
    for (int i = 0; i < 4; i++) begin
      d = ($urandom_range(3) == 0) ? 8'h00 : 8'($urandom);
      p = (^d) ^ 1'($urandom_range(1));
      s = 1'($urandom_range(1));
      send_frame(d, p, s, 10);
      idle(5);
    end
    drain();

    // Glitch on the line is rejected
    idx = 0;
    pulses = 0;
    send_bits(16'h0000, 1, 3);
    idle(30);
    check("glitch_no_write", str.str_tvalid, 32'd0);
    check("glitch_no_break", pulses, 32'd0);

    // Overflow with back-to-back frames
    for (int k = 1; k <= 5; k++) begin
      d = 8'(k);
      send_frame(d, ^d, 1'b1, 10);
    end
    check("ovf_set", error_fifo, 32'd1);
    idle(5);
    drain();
    check("ovf_sticky", error_fifo, {31'd0, merr});
    @(negedge clk);
    err_clr = 1'b1;
    merr = 1'b0;
    @(negedge clk);
    err_clr = 1'b0;
    check("ovf_cleared", error_fifo, 32'd0);

    // Line break held for 300 cycles
    idx = 0;
    pulses = 0;
    send_bits(16'h0000, 1, 300);
    check("break_one_pulse", pulses, 32'd1);
    check("break_no_write", str.str_tvalid, 32'd0);
    idle(30);
    check("break_no_more", pulses, 32'd1);
    send_frame(8'h5A, 1'b0, 1'b1, 10);
    drain();

    // Reset in the middle of the data bits
    send_frame(8'h33, 1'b0, 1'b1, 10);
    d = 8'($urandom);
    idx = 0;
    send_bits({8'h00, d[6:0], 1'b0}, 4, 10);
    @(negedge clk);
    rst = 1'b0;
    uart_rxd = 1'b1;
    mq.delete();
    merr = 1'b0;
    @(negedge clk);
    check("midrst_tvalid", str.str_tvalid, 32'd0);
    check("midrst_tdata", str.str_tdata, 32'd0);
    check("midrst_tuser", str.str_tuser, 32'd0);
    check("midrst_error_fifo", error_fifo, 32'd0);
    check("midrst_line_break", line_break, 32'd0);
    rst = 1'b1;
    idle(150);
    check("midrst_no_write", str.str_tvalid, 32'd0);

    // Divider change mid-frame takes effect on the next frame only
    d = 8'($urandom);
    fb = {1'b1, ^d, d, 1'b0};
    idx = 0;
    pulses = 0;
    send_bits({5'b00000, fb}, 4, 10);
    cfg_div = 16'd19;
    send_bits({9'd0, fb[10:4]}, 7, 10);
    model_frame(d, ^d, 1'b1, brk);
    idle(5);
    d2 = 8'($urandom);
    send_frame(d2, ^d2, 1'b1, 20);
    idle(5);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_rxq.md
# uart_rxq

Parametrised successor UART receiver for the stream UART path. It adds a runtime bit-period divider, a configurable receive FIFO, and per-byte frame/parity status carried alongside the data. It adds line-break detection and a sticky overflow flag with explicit clear. It sits between the `uart_rxd` pin and the consumer's RXD stream, in place of the fixed-rate receiver.

## Interface
- `DW`, 8, data bits per character (5..9)
- `PT`, "NONE", parity type: "EVEN", "ODD", "NONE"
- `SW`, 1, stop bits (1 or 2)
- `BW`, 16, width of the bit-period divider
- `FD`, 4, FIFO depth in characters; power of two, 2 or greater

- `clk`  input  1  clock
- `rst`  input  1  reset; synchronous, active-low (0 = reset)
- `cfg_div`  input  BW  bit period in clocks minus 1; minimum value 3
- `str_tvalid`  output  1  FIFO head valid
- `str_tdata`  output  DW  FIFO head character
- `str_tuser`  output  2  head status; [1] framing error, [0] parity error
- `str_tready`  input  1  consumer accepts the head
- `error_fifo`  output  1  sticky overflow flag
- `err_clr`  input  1  clears `error_fifo`
- `line_break`  output  1  one-cycle pulse on break detect
- `uart_rxd`  input  1  serial line; idle high, asynchronous to `clk`

## Operation
- `uart_rxd` passes through a 2-FF synchronizer; both FFs reset to 1. All logic below uses the synchronized value `rxs`.
- Bit period is P = `cfg_div`+1 and half period is H = P>>1. `cfg_div` is latched at start detection and held for the whole frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE: a falling edge on `rxs` goes to START and loads the counter with H.
  - START: when the counter expires, `rxs` is sampled. If it is 1 (glitch), return to IDLE with no other effect. Otherwise go to DATA with the counter set to P.
  - DATA: sample `DW` bits, LSB first, one every P clocks. Then go to PARITY if `PT`≠"NONE", else to STOP.
  - PARITY: sample one bit. Parity error is set if the received parity ≠ the computed parity (EVEN: XOR of data; ODD: inverted XOR).
  - STOP: sample `SW` bits. Framing error is set if any stop sample is 0.
- Frame-end decision at the last stop sample:
  - Break condition: all data bits 0, parity bit 0 (if present), and the stop sample is 0. Pulse `line_break`, do not write the FIFO, go to BREAK.
  - Otherwise: write {fe, pe, data} to the FIFO in the same cycle and return to IDLE.
- BREAK: wait for `rxs`=1, then go to IDLE. No further pulses are generated while the line stays low.
- FIFO behaviour:
  - Show-ahead: the head is always presented while the FIFO is non-empty.
  - A pop occurs on `str_tvalid`&&`str_tready`.
  - A write when full with no simultaneous pop drops the new character and sets `error_fifo`.
  - A write when full with a simultaneous pop is accepted.
- `error_fifo` stays set until `err_clr`=1. If `err_clr` and a new overflow occur in the same cycle, the set wins.
- `str_tdata`/`str_tuser` are don't-care while `str_tvalid`=0.

## Timing
- Reset values: `str_tvalid`=0, `str_tuser`=0, `str_tdata`=0, `error_fifo`=0, `line_break`=0. FSM is in IDLE, FIFO is empty, pointers are 0.
- Reset mid-frame aborts the frame. No write occurs and the FIFO contents are lost.
- Frame timing, with the `uart_rxd` falling edge at cycle 0:
  - `rxs` falls at cycle 2.
  - Start sample at cycle 2+H.
  - Data bit i sampled at cycle 2+H+P·(i+1).
  - Parity and stop bits follow at the same P spacing.
- `str_tvalid` rises 1 cycle after the FIFO write. Back-to-back frames need no idle gap beyond the stop bit(s).
- A pop takes effect at the clock edge; the next head is visible the following cycle.
- Full throughput: one character per frame time when `str_tready`=1.
- `line_break` is high for exactly 1 cycle, at the cycle after the last stop sample.

## Test plan
Defaults unless stated: `DW`=8, `PT`="EVEN", `SW`=1, `FD`=4, `cfg_div`=9 (P=10, H=5).
- **Good frame:** send 0xA5 with parity 0 -> FIFO write at cycle 107, `str_tvalid`=1 at 108, `str_tdata`=0xA5, `str_tuser`=00.
- **Parity error:** send 0xA5 with parity bit 1 -> `str_tdata`=0xA5, `str_tuser`=01. Send 0x3C with stop bit 0 -> `str_tuser`=10.
- **Glitch reject:** `uart_rxd` low for 3 cycles, then high -> FSM returns to IDLE, `str_tvalid` stays 0.
- **Overflow:** 5 frames (0x01..0x05) with `str_tready`=0 -> 4 characters stored, `error_fifo`=1 after the 5th stop sample. Draining yields 0x01..0x04. `err_clr` pulse -> `error_fifo`=0.
- **Break:** `uart_rxd` low for 300 cycles -> exactly one `line_break` pulse and no FIFO write. After release, frame 0x5A is received correctly.
- **Reset/divider:** assert `rst`=0 mid-DATA -> all outputs at reset values next cycle. Change `cfg_div` 9→19 mid-frame -> the current frame still decodes at P=10 and the next frame at P=20.
